// File: rtl/reg_wb_scheduler_if.sv
// Bundle of the issue, writeback, long-result and register-file write
// signals seen by the write-port scheduler.
interface reg_wb_scheduler_if;
  logic        issue_valid_i;
  logic [4:0]  issue_rs1_i;
  logic [4:0]  issue_rs2_i;
  logic [4:0]  issue_rd_i;
  logic        issue_regwrite_i;
  logic        issue_long_i;
  logic        issue_stall_o;

  logic        short_valid_i;
  logic [4:0]  short_rd_i;
  logic [31:0] short_data_i;
  logic        short_hold_o;

  logic        long_valid_i;
  logic [4:0]  long_rd_i;
  logic [31:0] long_data_i;
  logic        long_ready_o;

  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic        RegWrite_o;

  // The scheduler itself.
  modport slave (
    input  issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rd_i,
           issue_regwrite_i, issue_long_i,
           short_valid_i, short_rd_i, short_data_i,
           long_valid_i, long_rd_i, long_data_i,
    output issue_stall_o, short_hold_o, long_ready_o,
           RDaddr_o, RDdata_o, RegWrite_o
  );

  // The surrounding pipeline / long unit / register file.
  modport master (
    output issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rd_i,
           issue_regwrite_i, issue_long_i,
           short_valid_i, short_rd_i, short_data_i,
           long_valid_i, long_rd_i, long_data_i,
    input  issue_stall_o, short_hold_o, long_ready_o,
           RDaddr_o, RDdata_o, RegWrite_o
  );
endinterface

// File: rtl/reg_wb_scheduler.sv
// Register-file write-port scheduler: merges the short WB stream with
// out-of-order long results, buffers long results that lose the port,
// and keeps a scoreboard of in-flight long destinations to stall issue.
module reg_wb_scheduler #(
  parameter int FIFO_DEPTH   = 2,
  parameter int MAX_LONG     = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic clk_i,
  input logic rst_i,
  reg_wb_scheduler_if.slave bus
);

  localparam int CW = $clog2(MAX_LONG + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  logic [31:0]   sb;
  logic [CW-1:0] cnt;
  logic [4:0]    fifo_rd   [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [FW-1:0] fcnt;
  logic [AW-1:0] age;

  logic        empty;
  logic        full;
  logic        starve;
  logic        short_req;
  logic        long_acc;
  logic        long_keep;
  logic        tracked;
  logic        stall;
  logic        fire_set;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic        pop;
  logic        bypass;
  logic        push;
  logic        hold;
  logic        commit;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty     = (fcnt == '0);
  assign full      = (fcnt == FW'(FIFO_DEPTH));
  assign starve    = !empty && (age >= AW'(STARVE_LIMIT));
  assign short_req = bus.short_valid_i && (bus.short_rd_i != 5'd0);
  assign long_acc  = bus.long_valid_i && !full;
  assign long_keep = long_acc && (bus.long_rd_i != 5'd0);

  // Issue hazard check against registered scoreboard; no same-cycle clear bypass.
  assign tracked = bus.issue_long_i && bus.issue_regwrite_i && (bus.issue_rd_i != 5'd0);
  assign stall   = bus.issue_valid_i &&
                   (((bus.issue_rs1_i != 5'd0) && sb[bus.issue_rs1_i]) ||
                    ((bus.issue_rs2_i != 5'd0) && sb[bus.issue_rs2_i]) ||
                    (bus.issue_regwrite_i && (bus.issue_rd_i != 5'd0) && sb[bus.issue_rd_i]) ||
                    (tracked && (cnt == CW'(MAX_LONG))));
  assign fire_set = bus.issue_valid_i && !stall && tracked;

  // Write-port arbitration: starved head, then short, then head, then bypass.
  always_comb begin
    wr_en   = 1'b0;
    wr_rd   = 5'd0;
    wr_data = 32'd0;
    pop     = 1'b0;
    bypass  = 1'b0;
    hold    = 1'b0;
    if (!rst_i) begin
      if (starve) begin
        wr_en   = 1'b1;
        wr_rd   = fifo_rd[head];
        wr_data = fifo_data[head];
        pop     = 1'b1;
        hold    = short_req;
      end else if (short_req) begin
        wr_en   = 1'b1;
        wr_rd   = bus.short_rd_i;
        wr_data = bus.short_data_i;
      end else if (!empty) begin
        wr_en   = 1'b1;
        wr_rd   = fifo_rd[head];
        wr_data = fifo_data[head];
        pop     = 1'b1;
      end else if (long_keep) begin
        wr_en   = 1'b1;
        wr_rd   = bus.long_rd_i;
        wr_data = bus.long_data_i;
        bypass  = 1'b1;
      end
    end
  end

  assign push     = !rst_i && long_keep && !bypass;
  assign commit   = pop || bypass;
  assign set_mask = fire_set ? (32'd1 << bus.issue_rd_i) : 32'd0;
  assign clr_mask = commit ? (32'd1 << wr_rd) : 32'd0;

  assign bus.issue_stall_o = stall;
  assign bus.short_hold_o  = hold;
  assign bus.long_ready_o  = !full;
  assign bus.RegWrite_o    = wr_en;
  assign bus.RDaddr_o      = wr_rd;
  assign bus.RDdata_o      = wr_data;

  // Scoreboard, in-flight count, FIFO pointers and head age.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb   <= 32'd0;
      cnt  <= '0;
      head <= '0;
      tail <= '0;
      fcnt <= '0;
      age  <= '0;
    end else begin
      sb   <= (sb | set_mask) & ~clr_mask;
      cnt  <= cnt + CW'(fire_set) - CW'(commit);
      fcnt <= fcnt + FW'(push) - FW'(pop);
      if (pop)  head <= next_ptr(head);
      if (push) tail <= next_ptr(tail);
      if (empty || pop)
        age <= '0;
      else if (age != AW'(STARVE_LIMIT))
        age <= age + 1'b1;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by fcnt.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd[tail]   <= bus.long_rd_i;
      fifo_data[tail] <= bus.long_data_i;
    end
  end

endmodule

// File: doc/reg_wb_scheduler.md
# reg_wb_scheduler

Write-port scheduler and scoreboard for the 32x32 register file. Merges the in-order single-cycle writeback stream (short) and out-of-order multi-cycle results (long, e.g. MUL/DIV/load miss) onto the file's single write port. Tracks destinations of in-flight long ops and stalls issue on RAW/WAW hazards against them. Sits between the WB stage, the long-latency unit and the register file's RDaddr/RDdata/RegWrite inputs.

## Interface
- FIFO_DEPTH, 2, long-result holding buffer entries (≥1)
- MAX_LONG, 4, max tracked in-flight long ops (1..31)
- STARVE_LIMIT, 3, cycles a buffered long result may wait before forcing priority (≥1)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- issue_valid_i  in  1  instruction presented at issue
- issue_rs1_i / issue_rs2_i  in  5  source registers
- issue_rd_i  in  5  destination register
- issue_regwrite_i  in  1  instruction writes rd
- issue_long_i  in  1  instruction goes to the long unit
- issue_stall_o  out  1  hold issue this cycle
- short_valid_i  in  1  WB-stage write request
- short_rd_i  in  5;  short_data_i  in  32
- short_hold_o  out  1  WB write not taken; pipeline must freeze and re-present it
- long_valid_i  in  1;  long_rd_i  in  5;  long_data_i  in  32
- long_ready_o  out  1  long result accepted when valid && ready
- RDaddr_o  out  5;  RDdata_o  out  32;  RegWrite_o  out  1  to register file

## Operation
- State: 32-bit scoreboard sb (bit 0 always 0), in-flight counter cnt (0..MAX_LONG), FIFO of {rd,data}, head age counter age.
- Tracked issue: issue fire = issue_valid_i && !issue_stall_o; if also issue_long_i && issue_regwrite_i && issue_rd_i != 0, set sb[rd], cnt+1. Long op with rd 0 or regwrite 0 is untracked.
- issue_stall_o = issue_valid_i && ((rs1!=0 && sb[rs1]) || (rs2!=0 && sb[rs2]) || (issue_regwrite_i && rd!=0 && sb[rd]) || (tracked long && cnt==MAX_LONG)). Uses registered sb only; no same-cycle clear bypass.
- long_ready_o = FIFO not full. Long results with rd 0 accepted and dropped (no write, no cnt change).
- Write-port priority each cycle:
  1. age ≥ STARVE_LIMIT: FIFO head wins, short_hold_o=1.
  2. short_valid_i && short_rd_i!=0: short wins.
  3. FIFO non-empty: pop head.
  4. accepted long result with FIFO empty: written same cycle (bypass), not enqueued.
  5. else RegWrite_o=0.
- Accepted long result not written this cycle is pushed. Push and pop in same cycle allowed when not full.
- short with rd 0: ignored, never occupies port, never held.
- Long commit (write of nonzero long rd) clears sb[rd] and decrements cnt at that edge. Set and clear same cycle on different regs both apply; same reg cannot occur (WAW stall).
- age: 0 when FIFO empty or head popped; else +1 per cycle, saturating at STARVE_LIMIT.
- short_hold_o only when short_valid_i && short_rd_i!=0 && age ≥ STARVE_LIMIT.

## Timing
- Reset (async, immediate): sb=0, cnt=0, FIFO empty, age=0 → issue_stall_o=0, long_ready_o=1, short_hold_o=0, RegWrite_o=0, RDaddr_o=0, RDdata_o=0 while rst_i high.
- All outputs combinational from registered state and current inputs; no output registers.
- Short write latency 0 (same cycle to register file). Long bypass latency 0; buffered result earliest next cycle.
- Scoreboard clear visible to issue the cycle after commit; register file's write-through covers operand value.
- Reset mid-operation discards FIFO contents and in-flight tracking; long unit must be reset concurrently.

## Test plan
- Reset, no traffic: issue_stall_o=0, long_ready_o=1, RegWrite_o=0; issue rs1=5 not stalled.
- Issue long rd=7; next cycle issue add rs1=7 → stalled until long_valid rd=7 data=0x1234 writes (RegWrite_o=1, RDaddr_o=7); stall drops the following cycle.
- Short rd=3 and long rd=9 same cycle, FIFO empty → cycle0 writes x3, x9 buffered; cycle1 writes x9=long data.
- Continuous short writes with 1 buffered long result, STARVE_LIMIT=3 → on 4th cycle short_hold_o=1, head written, age→0; held short written next cycle.
- Issue 4 tracked longs (rd 1..4), 5th long rd=5 → stalled by cnt==MAX_LONG; commit of x2 releases it next cycle.
- FIFO_DEPTH=2 full under short stream → long_ready_o=0; async reset mid-stream → immediate empty FIFO, sb=0, long_ready_o=1.
